// File: rtl/birth_scroll_ctrl.sv
// Scans a 4-digit common-anode display through the birthday-code converter and scrolls
// a 4-digit window around the 8-digit code; start/stop pulses drive an IDLE/RUN/PAUSE FSM.
module birth_scroll_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic [6:0] seg_in,
  output logic [2:0] cnt,
  output logic [3:0] an,
  output logic [6:0] seg_out,
  output logic [2:0] offset,
  output logic       running
);

  localparam int SCAN_W   = $clog2(SCAN_DIV);
  localparam int SCROLL_W = $clog2(SCROLL_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic [SCAN_W-1:0]     scan_cnt_reg, scan_cnt_next;
  logic [SCROLL_W-1:0]   scroll_cnt_reg, scroll_cnt_next;
  logic [1:0]            scan_idx_reg, scan_idx_next;
  logic [2:0]            offset_reg, offset_next;
  logic                  scan_tick, scroll_tick, clear;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; stop has priority over start everywhere
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && !stop) state_next = RUN;
      RUN:     if (stop)           state_next = PAUSE;
      PAUSE:   if (stop)           state_next = IDLE;
               else if (start)     state_next = RUN;
      default:                     state_next = IDLE;
    endcase
  end

  assign clear       = (state_reg == PAUSE) && stop;
  assign scan_tick   = (state_reg != IDLE) && (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
  assign scroll_tick = (state_reg == RUN) && (scroll_cnt_reg == SCROLL_W'(SCROLL_DIV - 1));

  // Prescalers, scan index and window offset. The RUN cycle that sees stop still
  // counts and may shift; the PAUSE->IDLE edge wipes everything instead.
  always_comb begin
    scan_cnt_next   = scan_cnt_reg;
    scroll_cnt_next = scroll_cnt_reg;
    scan_idx_next   = scan_idx_reg;
    offset_next     = offset_reg;
    if (state_reg == IDLE || clear) begin
      scan_cnt_next   = '0;
      scroll_cnt_next = '0;
      scan_idx_next   = '0;
      offset_next     = '0;
    end else begin
      scan_cnt_next = scan_tick ? '0 : scan_cnt_reg + SCAN_W'(1);
      if (scan_tick) scan_idx_next = scan_idx_reg + 2'd1;
      if (state_reg == RUN) begin
        scroll_cnt_next = scroll_tick ? '0 : scroll_cnt_reg + SCROLL_W'(1);
        if (scroll_tick) offset_next = dir ? offset_reg - 3'd1 : offset_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_reg   <= '0;
      scroll_cnt_reg <= '0;
      scan_idx_reg   <= '0;
      offset_reg     <= '0;
    end else begin
      scan_cnt_reg   <= scan_cnt_next;
      scroll_cnt_reg <= scroll_cnt_next;
      scan_idx_reg   <= scan_idx_next;
      offset_reg     <= offset_next;
    end
  end

  // Output decode, purely from registered state
  always_comb begin
    cnt     = offset_reg + {1'b0, scan_idx_reg};
    offset  = offset_reg;
    running = (state_reg == RUN);
    if (state_reg == IDLE) begin
      an      = 4'b1111;
      seg_out = 7'h7F;
    end else begin
      an      = ~(4'b0001 << scan_idx_reg);
      seg_out = seg_in;
    end
  end

endmodule

// File: tb/tb_birth_scroll_ctrl.sv
// Directed bench for birth_scroll_ctrl with a behavioural birthday-code converter
// (digits 2,0,0,0,0,6,1,5) closing the cnt -> seg_in loop.
module tb_birth_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, dir;
  logic [6:0] seg_in, seg_out;
  logic [2:0] cnt, offset;
  logic [3:0] an;
  logic       running;

  int checks   = 0;
  int failures = 0;

  birth_scroll_ctrl #(.SCAN_DIV(4), .SCROLL_DIV(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .seg_in(seg_in), .cnt(cnt), .an(an), .seg_out(seg_out),
    .offset(offset), .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] conv(input logic [2:0] i);
    case (i)
      3'd0: conv = 7'h24;  // 2
      3'd1: conv = 7'h40;  // 0
      3'd2: conv = 7'h40;
      3'd3: conv = 7'h40;
      3'd4: conv = 7'h40;
      3'd5: conv = 7'h02;  // 6
      3'd6: conv = 7'h79;  // 1
      default: conv = 7'h12;  // 5
    endcase
  endfunction

  always_comb seg_in = conv(cnt);

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (an !== 4'b1111 || seg_out !== 7'h7F || cnt !== 3'd0 || running !== 1'b0 || offset !== 3'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d an=%b seg=%h cnt=%0d run=%b off=%0d required an=1111 seg=7f cnt=0 run=0 off=0",
                 i, an, seg_out, cnt, running, offset);
      end
      step(1);
    end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4] = '{7'h24, 7'h40, 7'h40, 7'h40};
    pulse_start();
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL start_running got=%b required=1", running);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (an !== ~(4'b0001 << k) || cnt !== 3'(k) || seg_out !== exp_seg[k]) begin
          failures++;
          $display("FAIL scan digit=%0d cyc=%0d an=%b cnt=%0d seg=%h required an=%b cnt=%0d seg=%h",
                   k, j, an, cnt, seg_out, ~(4'b0001 << k), k, exp_seg[k]);
        end
        step(1);
      end
    end
    $display("test_scan done");
  endtask

  task automatic check_window(input logic [2:0] off, input string tag);
    checks++;
    if (offset !== off) begin
      failures++;
      $display("FAIL %s_offset got=%0d required=%0d", tag, offset, off);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (cnt !== 3'(off + 3'(k)) || seg_out !== conv(3'(off + 3'(k)))) begin
          failures++;
          $display("FAIL %s_cnt digit=%0d got cnt=%0d seg=%h required cnt=%0d seg=%h",
                   tag, k, cnt, seg_out, 3'(off + 3'(k)), conv(3'(off + 3'(k))));
        end
        step(1);
      end
    end
  endtask

  task automatic test_scroll();
    // continues from test_scan: 16 RUN cycles elapsed
    check_window(3'd1, "fwd");
    pulse_stop(); pulse_stop();
    checks++;
    if (offset !== 3'd0 || an !== 4'b1111) begin
      failures++;
      $display("FAIL restart_idle off=%0d an=%b required off=0 an=1111", offset, an);
    end
    dir = 1'b1;
    pulse_start();
    step(16);
    check_window(3'd7, "rev");
    pulse_stop(); pulse_stop();
    dir = 1'b0;
    pulse_start();
    for (int s = 1; s <= 8; s++) begin
      step(16);
      checks++;
      if (offset !== 3'(s)) begin
        failures++;
        $display("FAIL fwd_shift n=%0d got=%0d required=%0d", s, offset, 3'(s));
      end
    end
    $display("test_scroll done");
  endtask

  task automatic test_pause();
    logic [3:0] seen;
    pulse_stop(); pulse_stop();
    pulse_start();           // scroll count 0
    step(10);                // scroll count 10
    pulse_stop();
    checks++;
    if (running !== 1'b0 || an === 4'b1111) begin
      failures++;
      $display("FAIL pause_enter run=%b an=%b required run=0 an!=1111", running, an);
    end
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (offset !== 3'd0 || an === 4'b1111) begin
        failures++;
        $display("FAIL pause_frozen cyc=%0d off=%0d an=%b required off=0 an scanning", i, offset, an);
      end
      seen = seen | ~an;
      step(1);
    end
    checks++;
    if (seen !== 4'b1111) begin
      failures++;
      $display("FAIL pause_scan digits_seen=%b required=1111", seen);
    end
    pulse_start();
    step(4);
    checks++;
    if (offset !== 3'd0 || running !== 1'b1) begin
      failures++;
      $display("FAIL resume_early off=%0d run=%b required off=0 run=1", offset, running);
    end
    step(1);
    checks++;
    if (offset !== 3'd1) begin
      failures++;
      $display("FAIL resume_shift got=%0d required=1", offset);
    end
    $display("test_pause done");
  endtask

  task automatic test_stop_priority();
    pulse_stop(); pulse_stop();
    checks++;
    if (offset !== 3'd0 || an !== 4'b1111 || seg_out !== 7'h7F || running !== 1'b0) begin
      failures++;
      $display("FAIL pause_to_idle off=%0d an=%b seg=%h run=%b required off=0 an=1111 seg=7f run=0",
               offset, an, seg_out, running);
    end
    start = 1'b1; stop = 1'b1; step(1);
    checks++;
    if (running !== 1'b0 || an !== 4'b1111) begin
      failures++;
      $display("FAIL both_in_idle run=%b an=%b required run=0 an=1111", running, an);
    end
    start = 1'b0;
    step(1);
    stop = 1'b0;
    checks++;
    if (an !== 4'b1111) begin
      failures++;
      $display("FAIL stop_in_idle an=%b required=1111", an);
    end
    pulse_start();
    step(3);
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    checks++;
    if (running !== 1'b0 || an === 4'b1111) begin
      failures++;
      $display("FAIL both_in_run run=%b an=%b required run=0 an!=1111", running, an);
    end
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    checks++;
    if (an !== 4'b1111 || running !== 1'b0) begin
      failures++;
      $display("FAIL both_in_pause an=%b run=%b required an=1111 run=0", an, running);
    end
    $display("test_stop_priority done");
  endtask

  task automatic test_async_reset();
    pulse_start();
    step(21);
    checks++;
    if (offset !== 3'd1 || an === 4'b1111) begin
      failures++;
      $display("FAIL pre_reset off=%0d an=%b required off=1 an!=1111", offset, an);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || seg_out !== 7'h7F || cnt !== 3'd0 || offset !== 3'd0 || running !== 1'b0) begin
      failures++;
      $display("FAIL async_reset an=%b seg=%h cnt=%0d off=%0d run=%b required an=1111 seg=7f cnt=0 off=0 run=0",
               an, seg_out, cnt, offset, running);
    end
    step(1);
    rst = 1'b0;
    step(5);
    checks++;
    if (an !== 4'b1111 || running !== 1'b0) begin
      failures++;
      $display("FAIL post_reset an=%b run=%b required an=1111 run=0", an, running);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_scroll();
    test_pause();
    test_stop_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
